// File: rtl/bms_fet_sequencer.sv
// Per-string FET gate sequencer: precharge-before-discharge, precharge timeout,
// latched faults with an explicit clear handshake, and an enforced off time.
module bms_fet_sequencer #(
    parameter int N_CH           = 2,
    parameter int PRECHG_TIMEOUT = 1000,
    parameter int MIN_OFF_CYCLES = 100,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      chg_req,
    input  logic [N_CH-1:0]      dsg_req,
    input  logic [N_CH-1:0]      pchg_done,
    input  logic [N_CH-1:0]      ch_fault,
    input  logic                 global_fault,
    input  logic [N_CH-1:0]      fault_clr,
    output logic [N_CH-1:0]      chg_gate,
    output logic [N_CH-1:0]      dsg_gate,
    output logic [N_CH-1:0]      pchg_gate,
    output logic [N_CH-1:0]      fault_latched,
    output logic [N_CH-1:0]      pchg_tmo,
    output logic [3*N_CH-1:0]    ch_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRECHG   = 3'd1,
        S_RUN      = 3'd2,
        S_FAULT    = 3'd3,
        S_COOLDOWN = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(PRECHG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            state_t           r_state;
            logic [CNT_W-1:0] r_cnt;
            logic             r_chg;
            logic             r_dsg;
            logic             r_pchg;
            logic             r_flt;
            logic             r_tmo;
            logic             w_f;

            assign w_f = ch_fault[gi] | global_fault;

            // Channel FSM; gates and flags are registered together with the state they describe
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_chg   <= 1'b0;
                    r_dsg   <= 1'b0;
                    r_pchg  <= 1'b0;
                    r_flt   <= 1'b0;
                    r_tmo   <= 1'b0;
                end else if (w_f && (r_state != S_FAULT)) begin
                    // A live fault overrides every other transition; this entry is not a timeout
                    r_state <= S_FAULT;
                    r_chg   <= 1'b0;
                    r_dsg   <= 1'b0;
                    r_pchg  <= 1'b0;
                    r_flt   <= 1'b1;
                    r_tmo   <= 1'b0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            r_flt <= 1'b0;
                            if (dsg_req[gi]) begin
                                r_state <= S_PRECHG;
                                r_cnt   <= '0;
                                r_chg   <= 1'b0;
                                r_dsg   <= 1'b0;
                                r_pchg  <= 1'b1;
                            end else if (chg_req[gi]) begin
                                r_state <= S_RUN;
                                r_chg   <= 1'b1;
                                r_dsg   <= 1'b0;
                                r_pchg  <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                                r_chg   <= 1'b0;
                                r_dsg   <= 1'b0;
                                r_pchg  <= 1'b0;
                            end
                        end

                        S_PRECHG: begin
                            r_chg <= 1'b0;
                            if (!dsg_req[gi]) begin
                                r_state <= S_IDLE;
                                r_dsg   <= 1'b0;
                                r_pchg  <= 1'b0;
                            end else if (pchg_done[gi]) begin
                                r_state <= S_RUN;
                                r_chg   <= chg_req[gi];
                                r_dsg   <= 1'b1;
                                r_pchg  <= 1'b0;
                            end else if (r_cnt == TMO_LAST) begin
                                r_state <= S_FAULT;
                                r_dsg   <= 1'b0;
                                r_pchg  <= 1'b0;
                                r_flt   <= 1'b1;
                                r_tmo   <= 1'b1;
                            end else begin
                                r_cnt   <= r_cnt + CNT_ONE;
                                r_dsg   <= 1'b0;
                                r_pchg  <= 1'b1;
                            end
                        end

                        S_RUN: begin
                            r_pchg <= 1'b0;
                            if (!chg_req[gi] && !dsg_req[gi]) begin
                                r_state <= S_IDLE;
                                r_chg   <= 1'b0;
                                r_dsg   <= 1'b0;
                            end else begin
                                // Discharge raised while running just follows; no second precharge
                                r_state <= S_RUN;
                                r_chg   <= chg_req[gi];
                                r_dsg   <= dsg_req[gi];
                            end
                        end

                        S_FAULT: begin
                            r_chg  <= 1'b0;
                            r_dsg  <= 1'b0;
                            r_pchg <= 1'b0;
                            if (fault_clr[gi] && !w_f) begin
                                r_state <= S_COOLDOWN;
                                r_cnt   <= '0;
                                r_flt   <= 1'b0;
                            end else begin
                                r_state <= S_FAULT;
                                r_flt   <= 1'b1;
                            end
                        end

                        S_COOLDOWN: begin
                            r_chg  <= 1'b0;
                            r_dsg  <= 1'b0;
                            r_pchg <= 1'b0;
                            r_flt  <= 1'b0;
                            if (r_cnt == OFF_LAST) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_COOLDOWN;
                                r_cnt   <= r_cnt + CNT_ONE;
                            end
                        end

                        default: begin
                            // Corrupted state: park in FAULT with all gates off
                            r_state <= S_FAULT;
                            r_cnt   <= '0;
                            r_chg   <= 1'b0;
                            r_dsg   <= 1'b0;
                            r_pchg  <= 1'b0;
                            r_flt   <= 1'b1;
                            r_tmo   <= 1'b0;
                        end
                    endcase
                end
            end

            assign chg_gate[gi]       = r_chg;
            assign dsg_gate[gi]       = r_dsg;
            assign pchg_gate[gi]      = r_pchg;
            assign fault_latched[gi]  = r_flt;
            assign pchg_tmo[gi]       = r_tmo;
            assign ch_state[3*gi +: 3] = r_state;
        end
    endgenerate

endmodule

// File: tb/tb_bms_fet_sequencer.sv
// Self-checking bench for bms_fet_sequencer: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of each channel.
module tb_bms_fet_sequencer;

    localparam int N_CH  = 2;
    localparam int TMO   = 8;
    localparam int OFF   = 4;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_CH-1:0]   chg_req, dsg_req, pchg_done, ch_fault, fault_clr;
    logic              global_fault;
    logic [N_CH-1:0]   chg_gate, dsg_gate, pchg_gate, fault_latched, pchg_tmo;
    logic [3*N_CH-1:0] ch_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bms_fet_sequencer #(
        .N_CH(N_CH), .PRECHG_TIMEOUT(TMO), .MIN_OFF_CYCLES(OFF), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .chg_req(chg_req), .dsg_req(dsg_req), .pchg_done(pchg_done),
        .ch_fault(ch_fault), .global_fault(global_fault), .fault_clr(fault_clr),
        .chg_gate(chg_gate), .dsg_gate(dsg_gate), .pchg_gate(pchg_gate),
        .fault_latched(fault_latched), .pchg_tmo(pchg_tmo), .ch_state(ch_state)
    );

    // Behavioural model: st is the state code, n counts cycles already spent in st
    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] n;
        logic        chg, dsg, pchg, flt, tmo;
    } mch_t;

    mch_t m [N_CH];

    function automatic mch_t model_step(mch_t c, logic chg, logic dsg, logic done,
                                        logic f, logic clr);
        mch_t x;
        logic [2:0] nxt;
        logic timeout;
        x = c;
        nxt = c.st;
        timeout = 1'b0;
        if (f && c.st != 3'd3) nxt = 3'd3;
        else begin
            case (c.st)
                3'd0: if (dsg) nxt = 3'd1; else if (chg) nxt = 3'd2;
                3'd1: if (!dsg) nxt = 3'd0;
                      else if (done) nxt = 3'd2;
                      else if (c.n + 1 >= TMO) begin nxt = 3'd3; timeout = 1'b1; end
                3'd2: if (!chg && !dsg) nxt = 3'd0;
                3'd3: if (clr && !f) nxt = 3'd4;
                3'd4: if (c.n + 1 >= OFF) nxt = 3'd0;
                default: nxt = 3'd0;
            endcase
        end
        if (nxt != c.st) begin
            x.n = 0;
            if (nxt == 3'd3) x.tmo = timeout;
        end else begin
            x.n = c.n + 1;
        end
        x.st   = nxt;
        x.pchg = (nxt == 3'd1);
        x.flt  = (nxt == 3'd3);
        x.chg  = (nxt == 3'd2) && chg;
        x.dsg  = (nxt == 3'd2) && dsg;
        return x;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (!rst_n) m[c] <= '0;
            else m[c] <= model_step(m[c], chg_req[c], dsg_req[c], pchg_done[c],
                                    ch_fault[c] | global_fault, fault_clr[c]);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        chg_req = 2'b11; dsg_req = 2'b11; pchg_done = 2'b01;
        ch_fault = 2'b00; global_fault = 1'b0; fault_clr = 2'b10;
        tick(); tick(); tick();
        checks++;
        if ({chg_gate, dsg_gate, pchg_gate, fault_latched, pchg_tmo, ch_state} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {chg_gate, dsg_gate, pchg_gate, fault_latched, pchg_tmo, ch_state});
        end
        chg_req = 2'b00; dsg_req = 2'b00; pchg_done = 2'b00; fault_clr = 2'b00;
        rst_n = 1'b1;
        tick();
        checks++;
        if (ch_state !== 6'd0) begin
            errors++;
            $display("FAIL reset_idle_after got=%b want=000000", ch_state);
        end
    endtask

    task automatic test_prechg_done();
        dsg_req = 2'b01;
        tick();
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({pchg_gate[0], dsg_gate[0], chg_gate[0]} !== 3'b100) begin
                errors++;
                $display("FAIL s1_prechg cyc%0d got=%b want=100", i, {pchg_gate[0], dsg_gate[0], chg_gate[0]});
            end
            if (i == 3) pchg_done = 2'b01;
            tick();
        end
        checks++;
        if ({pchg_gate[0], dsg_gate[0], ch_state[2:0]} !== 5'b01010) begin
            errors++;
            $display("FAIL s1_run got=%b want=01010", {pchg_gate[0], dsg_gate[0], ch_state[2:0]});
        end
        checks++;
        if ({chg_gate[1], dsg_gate[1], pchg_gate[1], ch_state[5:3]} !== 6'd0) begin
            errors++;
            $display("FAIL s1_ch1_quiet got=%b want=000000", {chg_gate[1], dsg_gate[1], pchg_gate[1], ch_state[5:3]});
        end
        dsg_req = 2'b00; pchg_done = 2'b00;
        tick();
        checks++;
        if ({dsg_gate[0], ch_state[2:0]} !== 4'b0000) begin
            errors++;
            $display("FAIL s1_back_idle got=%b want=0000", {dsg_gate[0], ch_state[2:0]});
        end
    endtask

    task automatic test_timeout();
        int cnt;
        dsg_req = 2'b10;
        tick();
        cnt = 0;
        while (pchg_gate[1] === 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != TMO) begin
            errors++;
            $display("FAIL s2_prechg_len got=%0d want=%0d", cnt, TMO);
        end
        checks++;
        if ({fault_latched[1], pchg_tmo[1], ch_state[5:3], ch_state[2:0], fault_latched[0]} !== 9'b11_011_000_0) begin
            errors++;
            $display("FAIL s2_fault got=%b want=110110000", {fault_latched[1], pchg_tmo[1], ch_state[5:3], ch_state[2:0], fault_latched[0]});
        end
        dsg_req = 2'b00; fault_clr = 2'b10;
        tick();
        fault_clr = 2'b00;
        cnt = 0;
        while (ch_state[5:3] === 3'd4 && cnt < 20) begin
            cnt++;
            checks++;
            if ({fault_latched[1], pchg_tmo[1]} !== 2'b01) begin
                errors++;
                $display("FAIL s2_cool_flags got=%b want=01", {fault_latched[1], pchg_tmo[1]});
            end
            tick();
        end
        checks++;
        if (cnt != OFF || ch_state[5:3] !== 3'd0 || pchg_tmo[1] !== 1'b1) begin
            errors++;
            $display("FAIL s2_cooldown len=%0d want=%0d state=%0d tmo=%b want state=0 tmo=1", cnt, OFF, ch_state[5:3], pchg_tmo[1]);
        end
    endtask

    task automatic test_global_fault();
        int cnt;
        chg_req = 2'b11; dsg_req = 2'b11; pchg_done = 2'b11;
        tick(); tick();
        checks++;
        if ({chg_gate, dsg_gate, pchg_gate} !== 6'b111100) begin
            errors++;
            $display("FAIL s3_both_run got=%b want=111100", {chg_gate, dsg_gate, pchg_gate});
        end
        global_fault = 1'b1; fault_clr = 2'b11;
        tick();
        global_fault = 1'b0; fault_clr = 2'b00;
        checks++;
        if ({chg_gate, dsg_gate, pchg_gate, fault_latched, pchg_tmo, ch_state} !== {10'b0000001100, 6'b011011}) begin
            errors++;
            $display("FAIL s3_fault got=%b want=0000001100011011", {chg_gate, dsg_gate, pchg_gate, fault_latched, pchg_tmo, ch_state});
        end
        tick();
        checks++;
        if (fault_latched !== 2'b11) begin
            errors++;
            $display("FAIL s3_clr_no_memory got=%b want=11", fault_latched);
        end
        fault_clr = 2'b11;
        tick();
        fault_clr = 2'b00;
        cnt = 0;
        while (ch_state === 6'b100100 && cnt < 20) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != OFF || ch_state !== 6'd0 || {chg_gate, dsg_gate, pchg_gate} !== 6'd0) begin
            errors++;
            $display("FAIL s3_cooldown len=%0d want=%0d state=%b want=000000", cnt, OFF, ch_state);
        end
        chg_req = 2'b00; dsg_req = 2'b00; pchg_done = 2'b00;
        tick();
    endtask

    task automatic test_done_tie();
        dsg_req = 2'b01;
        tick();
        for (int i = 1; i <= TMO; i++) begin
            checks++;
            if (pchg_gate[0] !== 1'b1) begin
                errors++;
                $display("FAIL s4_prechg cyc%0d got=%b want=1", i, pchg_gate[0]);
            end
            if (i == TMO) pchg_done = 2'b01;
            tick();
        end
        checks++;
        if ({ch_state[2:0], dsg_gate[0], fault_latched[0], pchg_tmo[0]} !== 6'b010100) begin
            errors++;
            $display("FAIL s4_done_wins got=%b want=010100", {ch_state[2:0], dsg_gate[0], fault_latched[0], pchg_tmo[0]});
        end
        dsg_req = 2'b00; pchg_done = 2'b00;
        tick();
    endtask

    task automatic test_cooldown_refault();
        int cnt;
        ch_fault = 2'b01;
        tick();
        ch_fault = 2'b00; fault_clr = 2'b01;
        tick();
        fault_clr = 2'b00;
        checks++;
        if (ch_state[2:0] !== 3'd4) begin
            errors++;
            $display("FAIL s5_cool1 got=%0d want=4", ch_state[2:0]);
        end
        tick();
        checks++;
        if (ch_state[2:0] !== 3'd4) begin
            errors++;
            $display("FAIL s5_cool2 got=%0d want=4", ch_state[2:0]);
        end
        ch_fault = 2'b01;
        tick();
        ch_fault = 2'b00;
        checks++;
        if ({ch_state[2:0], fault_latched[0], pchg_tmo[0]} !== 5'b01110) begin
            errors++;
            $display("FAIL s5_refault got=%b want=01110", {ch_state[2:0], fault_latched[0], pchg_tmo[0]});
        end
        fault_clr = 2'b01;
        tick();
        fault_clr = 2'b00;
        cnt = 0;
        while (ch_state[2:0] === 3'd4 && cnt < 20) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != OFF || ch_state[2:0] !== 3'd0) begin
            errors++;
            $display("FAIL s5_full_cooldown len=%0d want=%0d state=%0d", cnt, OFF, ch_state[2:0]);
        end
    endtask

    task automatic test_reset_midop();
        int cnt;
        dsg_req = 2'b10;
        tick();
        cnt = 0;
        while (fault_latched[1] !== 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        dsg_req = 2'b11;
        tick(); tick();
        checks++;
        if ({ch_state, pchg_tmo[1]} !== 7'b011_001_1) begin
            errors++;
            $display("FAIL s6_setup got=%b want=0110011", {ch_state, pchg_tmo[1]});
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({chg_gate, dsg_gate, pchg_gate, fault_latched, pchg_tmo, ch_state} !== 16'h0) begin
            errors++;
            $display("FAIL s6_reset got=%h want=0", {chg_gate, dsg_gate, pchg_gate, fault_latched, pchg_tmo, ch_state});
        end
        rst_n = 1'b1; dsg_req = 2'b00;
        tick();
    endtask

    task automatic test_random(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                checks++;
                if ({chg_gate[c], dsg_gate[c], pchg_gate[c], fault_latched[c], pchg_tmo[c], ch_state[3*c +: 3]} !==
                    {m[c].chg, m[c].dsg, m[c].pchg, m[c].flt, m[c].tmo, m[c].st}) begin
                    errors++;
                    $display("FAIL random ch%0d cyc%0d dut=%b model=%b", c, k,
                             {chg_gate[c], dsg_gate[c], pchg_gate[c], fault_latched[c], pchg_tmo[c], ch_state[3*c +: 3]},
                             {m[c].chg, m[c].dsg, m[c].pchg, m[c].flt, m[c].tmo, m[c].st});
                end
                checks++;
                if ((pchg_gate[c] & dsg_gate[c]) !== 1'b0) begin
                    errors++;
                    $display("FAIL random_exclusive ch%0d cyc%0d pchg=%b dsg=%b want not both", c, k, pchg_gate[c], dsg_gate[c]);
                end
                if ($urandom_range(0, 99) < 10) chg_req[c] = ~chg_req[c];
                if ($urandom_range(0, 99) < 10) dsg_req[c] = ~dsg_req[c];
                pchg_done[c] = ($urandom_range(0, 99) < 12);
                ch_fault[c]  = ($urandom_range(0, 99) < 2);
                fault_clr[c] = ($urandom_range(0, 99) < 25);
            end
            global_fault = ($urandom_range(0, 199) < 2);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        chg_req = '0; dsg_req = '0; pchg_done = '0;
        ch_fault = '0; global_fault = 1'b0; fault_clr = '0;
        test_reset();
        test_prechg_done();
        test_timeout();
        test_global_fault();
        test_done_tie();
        test_cooldown_refault();
        test_reset_midop();
        test_random(1500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
